memory_access_unit: RTL and testbench
=====================================

// Module: memory_access_unit
// PURPOSE
// - Responder side of the MFU memory request channel: accepts in-order LOAD/STORE/INPUT/OUTPUT requests.
// - Executes them against an internal word-addressed data RAM and 8-bit I/O streams.
// - Returns load/input results to the CDB arbiter as {rsv_id, data}; stores and outputs return nothing.
// PARAMETERS
// - ADDR_W          14   word-address bits used; RAM depth 2**ADDR_W words of DATA_W
// - OUTSTANDING_W    2   up to 2**OUTSTANDING_W load/input results in flight or queued
// PORTS
// - clk          in   1         clock
// - nrst         in   1         reset nrst, synchronous, active-high
// - req_valid    in   1         request valid
// - req_opcode   in   INSTR_W   I_LOAD/I_LOADB/I_LOADR/I_INPUT/I_STORE/I_STOREB/I_STORER/I_OUTPUT
// - req_rsv_id   in   RSV_ID_W  ROB tag of the request
// - req_address  in   DATA_W    final computed address (no offset math here)
// - req_data     in   DATA_W    store/output data
// - req_ready    out  1         request accepted when valid&ready
// - cdb          out  CDB_W     {rsv_id, data} result
// - cdb_valid    out  1         result valid
// - cdb_ready    in   1         CDB grant
// - in_data      in   8         input byte stream
// - in_valid     in   1         input byte available
// - in_ready     out  1         input byte consumed
// - out_data     out  8         output byte
// - out_valid    out  1         output byte valid
// - out_ready    in   1         output sink ready
// BEHAVIOUR
// - Reset (nrst=1 at clk edge) clears all state and flushes every in-flight result.
//   - req_ready=0, cdb=0, cdb_valid=0, in_ready=0, out_data=0, out_valid=0, outstanding=0.
//   - RAM contents are NOT cleared.
// - Word index = req_address[ADDR_W-1:0]; upper bits ignored, no fault.
// - All LOAD variants behave identically, as do all STORE variants.
// - STORE: RAM written in the accept cycle.
//   - Always acceptable when no reset.
//   - A load accepted the next cycle sees the new value.
// - OUTPUT: accepted only if output reg empty or (out_valid&out_ready) this cycle.
//   - Loads out_data=req_data[7:0] and sets out_valid.
//   - out_valid holds until out_ready.
// - INPUT: accepted only if in_valid and credit available.
//   - in_ready is asserted combinationally in exactly the accept cycle.
//   - Result = zero-extended in_data.
// - LOAD: accepted only if credit available.
// - Credit: outstanding < 2**OUTSTANDING_W.
//   - outstanding +1 on LOAD/INPUT accept, -1 on cdb_valid&cdb_ready.
//   - Simultaneous inc and dec leaves it unchanged.
// - Pipeline: S0 accept (RAM addr registered) -> S1 RAM data out -> S2 write into result queue.
//   - Min latency from accept edge to cdb_valid=1 is 2 cycles.
//   - Throughput is 1 request/cycle.
// - Result queue: depth 2**OUTSTANDING_W, strict request order; INPUT results stay ordered with loads.
//   - cdb/cdb_valid come from the queue head; cdb is stable while cdb_valid&!cdb_ready.
//   - Credit guarantees the queue never overflows and never drops a result.
// - Unknown opcode with req_valid: accepted, no effect (req_ready=1).
// STRUCTURE
// - fcpu_pkg supplies RSV_ID_W, INSTR_W, DATA_W, CDB_W and opcode constants.
//   - Add typedef mau_pipe_t {valid, rsv_id, is_input, in_byte} to fcpu_pkg.
// - Sub-module: existing fifo (FIFO_DEPTH_W=OUTSTANDING_W, DATA_W=CDB_W) as result queue.
// - RAM inferred inline as single-port BRAM with registered output.
// TESTING
// - STORE addr 0x10 data 0xDEADBEEF, next cycle LOAD addr 0x10 rsv 3
//   -> cdb={3,0xDEADBEEF}, cdb_valid 2 cycles after LOAD accept.
// - 4 back-to-back LOADs (rsv 1..4), cdb_ready=0
//   -> 5th LOAD stalls with req_ready=0.
//   - Raise cdb_ready: results appear in order 1,2,3,4 and the 5th is accepted after first drain.
// - INPUT rsv 7 with in_valid=0 for 5 cycles -> req_ready=0, in_ready=0.
//   - in_valid=1, in_data=0x41 -> in_ready pulses once; cdb={7,0x00000041}.
// - OUTPUT 0x1234_5678 with out_ready=0 -> out_data=0x78 held, out_valid=1.
//   - Second OUTPUT stalls until out_ready=1.
// - LOAD addr 0x10000 with ADDR_W=14 -> returns word 0 contents.
// - nrst=1 with 2 loads in flight -> no cdb_valid afterwards, outstanding=0, all outputs 0.

Source files
------------

// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fcpu_pkg
//  Brief    : Shared widths, opcodes and memory-unit pipeline types.
//  Revision : 1.0
// ============================================================================
package fcpu_pkg;

    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_LOAD   = 6'h10;
    localparam logic [INSTR_W-1:0] I_LOADB  = 6'h11;
    localparam logic [INSTR_W-1:0] I_LOADR  = 6'h12;
    localparam logic [INSTR_W-1:0] I_STORE  = 6'h14;
    localparam logic [INSTR_W-1:0] I_STOREB = 6'h15;
    localparam logic [INSTR_W-1:0] I_STORER = 6'h16;
    localparam logic [INSTR_W-1:0] I_INPUT  = 6'h18;
    localparam logic [INSTR_W-1:0] I_OUTPUT = 6'h19;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_INPUT  = 3'd3,
        OP_OUTPUT = 3'd4
    } mau_op_e;

    typedef struct packed {
        logic                valid;
        logic [RSV_ID_W-1:0] rsv_id;
        logic                is_input;
        logic [7:0]          in_byte;
    } mau_pipe_t;

    // Collapses the addressing-mode variants into one memory operation class.
    function automatic mau_op_e decode_op(input logic [INSTR_W-1:0] opcode);
        mau_op_e op;
        case (opcode)
            I_LOAD, I_LOADB, I_LOADR:    op = OP_LOAD;
            I_STORE, I_STOREB, I_STORER: op = OP_STORE;
            I_INPUT:                     op = OP_INPUT;
            I_OUTPUT:                    op = OP_OUTPUT;
            default:                     op = OP_NONE;
        endcase
        decode_op = op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fifo
//  Brief    : Show-ahead synchronous FIFO, 2**FIFO_DEPTH_W entries.
//  Revision : 1.0
// ============================================================================
module fifo #(
    parameter int FIFO_DEPTH_W = 2,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int c_DEPTH = 1 << FIFO_DEPTH_W;

    logic [DATA_W-1:0]     mem_q [c_DEPTH];
    logic [FIFO_DEPTH_W:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_W:0] rd_ptr_q, rd_ptr_d;
    logic                  w_push, w_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[FIFO_DEPTH_W] != rd_ptr_q[FIFO_DEPTH_W]) &&
                   (wr_ptr_q[FIFO_DEPTH_W-1:0] == rd_ptr_q[FIFO_DEPTH_W-1:0]);
        w_push   = wr_en && !full;
        w_pop    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{FIFO_DEPTH_W{1'b0}}, w_push};
        rd_ptr_d = rd_ptr_q + {{FIFO_DEPTH_W{1'b0}}, w_pop};
        rd_data  = mem_q[rd_ptr_q[FIFO_DEPTH_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[FIFO_DEPTH_W-1:0]] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : memory_access_unit
//  Brief    : In-order LOAD/STORE/INPUT/OUTPUT responder with data RAM,
//             byte I/O streams and an ordered CDB result queue.
//  Revision : 1.0
// ============================================================================
module memory_access_unit
    import fcpu_pkg::*;
#(
    parameter int ADDR_W        = 14,
    parameter int OUTSTANDING_W = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                req_valid,
    input  logic [INSTR_W-1:0]  req_opcode,
    input  logic [RSV_ID_W-1:0] req_rsv_id,
    input  logic [DATA_W-1:0]   req_address,
    input  logic [DATA_W-1:0]   req_data,
    output logic                req_ready,
    output logic [CDB_W-1:0]    cdb,
    output logic                cdb_valid,
    input  logic                cdb_ready,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int                     c_RAM_DEPTH = 1 << ADDR_W;
    localparam logic [OUTSTANDING_W:0] c_MAX_OUT   = {1'b1, {OUTSTANDING_W{1'b0}}};

    logic [DATA_W-1:0]      ram_q [c_RAM_DEPTH];
    logic [DATA_W-1:0]      ram_rdata_q;
    mau_pipe_t              pipe_q, pipe_d;
    logic [OUTSTANDING_W:0] outstanding_q, outstanding_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;

    mau_op_e                w_op;
    logic [ADDR_W-1:0]      w_idx;
    logic                   w_credit, w_out_free, w_accept, w_is_rd, w_pop;
    logic [CDB_W-1:0]       w_push_data, w_fifo_head;
    logic                   w_fifo_empty;
    logic                   unused_fifo_full;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^req_address[DATA_W-1:ADDR_W];

    always_comb begin
        w_op       = decode_op(req_opcode);
        w_idx      = req_address[ADDR_W-1:0];
        w_credit   = (outstanding_q < c_MAX_OUT);
        w_out_free = !out_valid_q || out_ready;
        req_ready  = 1'b0;
        if (!nrst) begin
            case (w_op)
                OP_LOAD:   req_ready = w_credit;
                OP_INPUT:  req_ready = in_valid && w_credit;
                OP_OUTPUT: req_ready = w_out_free;
                default:   req_ready = 1'b1;
            endcase
        end
        w_accept = req_valid && req_ready;
        in_ready = w_accept && (w_op == OP_INPUT);
        w_is_rd  = w_accept && ((w_op == OP_LOAD) || (w_op == OP_INPUT));
    end

    // Credit counts everything from accept until the CDB grant, so the queue
    // can never be asked to hold more than its depth.
    always_comb begin
        cdb_valid     = !w_fifo_empty;
        cdb           = cdb_valid ? w_fifo_head : '0;
        w_pop         = cdb_valid && cdb_ready;
        outstanding_d = outstanding_q + {{OUTSTANDING_W{1'b0}}, w_is_rd}
                                      - {{OUTSTANDING_W{1'b0}}, w_pop};

        pipe_d          = '0;
        pipe_d.valid    = w_is_rd;
        pipe_d.rsv_id   = req_rsv_id;
        pipe_d.is_input = (w_op == OP_INPUT);
        pipe_d.in_byte  = in_data;

        w_push_data = {pipe_q.rsv_id,
                       pipe_q.is_input ? {{(DATA_W-8){1'b0}}, pipe_q.in_byte} : ram_rdata_q};

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (w_accept && (w_op == OP_OUTPUT)) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[7:0];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    // Single-port RAM, read-first, registered output; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && (w_op == OP_STORE)) begin
            ram_q[w_idx] <= req_data;
        end
        ram_rdata_q <= ram_q[w_idx];
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            pipe_q        <= '0;
            outstanding_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            pipe_q        <= pipe_d;
            outstanding_q <= outstanding_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    fifo #(
        .FIFO_DEPTH_W (OUTSTANDING_W),
        .DATA_W       (CDB_W)
    ) u_result_q (
        .clk     (clk),
        .nrst    (nrst),
        .wr_en   (pipe_q.valid),
        .wr_data (w_push_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_head),
        .empty   (w_fifo_empty),
        .full    (unused_fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_access_unit
//  Brief    : Randomized bench with a queue-based reference model of the unit.
//  Revision : 1.0
// ============================================================================
module tb_memory_access_unit;
    import fcpu_pkg::*;

    localparam int ADDR_W = 14;
    localparam int OW     = 2;

    logic                clk = 1'b0;
    logic                nrst = 1'b1;
    logic                req_valid = 1'b0;
    logic [INSTR_W-1:0]  req_opcode = '0;
    logic [RSV_ID_W-1:0] req_rsv_id = '0;
    logic [DATA_W-1:0]   req_address = '0;
    logic [DATA_W-1:0]   req_data = '0;
    logic                req_ready;
    logic [CDB_W-1:0]    cdb;
    logic                cdb_valid;
    logic                cdb_ready = 1'b1;
    logic [7:0]          in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready = 1'b1;

    memory_access_unit #(.ADDR_W(ADDR_W), .OUTSTANDING_W(OW)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_rsv_id(req_rsv_id),
        .req_address(req_address), .req_data(req_data), .req_ready(req_ready),
        .cdb(cdb), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CDB_W-1:0] val;
        int               rdy;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] mem_m [int];
    logic              m_out_v = 1'b0;
    logic [7:0]        m_out_d = '0;
    bit                model_on = 1'b0;
    int                cyc = 0;
    int                errors = 0;
    int                checks = 0;
    int                popped[$];

    logic              s_req_ready, s_in_ready, s_cdb_valid, s_out_valid;
    logic [CDB_W-1:0]  s_cdb;
    logic [7:0]        s_out_data;

    logic [ADDR_W-1:0]  addrs [8] = '{14'h0010, 14'h0000, 14'h0001, 14'h0002,
                                      14'h3FFF, 14'h0100, 14'h0055, 14'h2AAA};
    logic [INSTR_W-1:0] ops [10] = '{I_LOAD, I_LOADB, I_LOADR, I_STORE, I_STOREB,
                                     I_STORER, I_INPUT, I_OUTPUT, 6'h00, 6'h3F};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 1 load, 2 store, 3 input, 4 output, 0 anything else
    function automatic int kind(input logic [INSTR_W-1:0] op);
        if (op inside {I_LOAD, I_LOADB, I_LOADR})    return 1;
        if (op inside {I_STORE, I_STOREB, I_STORER}) return 2;
        if (op == I_INPUT)                           return 3;
        if (op == I_OUTPUT)                          return 4;
        return 0;
    endfunction

    // One clock: compare at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        int k, idx;
        bit credit, exp_ready, exp_valid, acc;
        @(negedge clk);
        s_req_ready = req_ready;  s_in_ready  = in_ready;
        s_cdb_valid = cdb_valid;  s_cdb       = cdb;
        s_out_valid = out_valid;  s_out_data  = out_data;
        if (model_on) begin
            k         = kind(req_opcode);
            idx       = int'(req_address[ADDR_W-1:0]);
            credit    = (q.size() < (1 << OW));
            exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
            case (k)
                1:       exp_ready = credit;
                3:       exp_ready = in_valid && credit;
                4:       exp_ready = !m_out_v || out_ready;
                default: exp_ready = 1'b1;
            endcase
            if (nrst) exp_ready = 1'b0;
            acc = req_valid && exp_ready;
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("in_ready",  64'(in_ready),  64'(acc && k == 3));
            chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
            chk("cdb",       64'(cdb),       exp_valid ? 64'(q[0].val) : 64'd0);
            chk("out_valid", 64'(out_valid), 64'(m_out_v));
            chk("out_data",  64'(out_data),  64'(m_out_d));
            if (nrst) begin
                q.delete();
                m_out_v = 1'b0;
                m_out_d = '0;
            end else begin
                if (exp_valid && cdb_ready) begin
                    popped.push_back(int'(q[0].val[CDB_W-1:DATA_W]));
                    void'(q.pop_front());
                end
                if (acc && k == 4) begin
                    m_out_v = 1'b1;
                    m_out_d = req_data[7:0];
                end else if (out_ready) begin
                    m_out_v = 1'b0;
                end
                if (acc && k == 1) q.push_back('{{req_rsv_id, mem_m[idx]}, cyc + 2});
                if (acc && k == 3) q.push_back('{{req_rsv_id, 24'h0, in_data}, cyc + 2});
                if (acc && k == 2) mem_m[idx] = req_data;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic req(input logic [INSTR_W-1:0] op, input int rsv,
                       input logic [31:0] addr, input logic [31:0] data);
        req_valid   = 1'b1;
        req_opcode  = op;
        req_rsv_id  = RSV_ID_W'(rsv);
        req_address = addr;
        req_data    = data;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_opcode = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a load pending: nothing may be accepted.
        nrst = 1'b1;
        req(I_LOAD, 1, 32'h10, 32'h0);
        cycle();
        model_on = 1'b1;
        cycle();
        chk("rst_req_ready", 64'(s_req_ready), 64'd0);
        chk("rst_cdb_valid", 64'(s_cdb_valid), 64'd0);
        chk("rst_cdb",       64'(s_cdb),       64'd0);
        chk("rst_out_valid", 64'(s_out_valid), 64'd0);
        chk("rst_out_data",  64'(s_out_data),  64'd0);
        nrst = 1'b0;
        idle();

        for (int i = 0; i < 8; i++) begin
            req(I_STORE, 0, {18'h0, addrs[i]}, $urandom);
            cycle();
        end

        // Store then load back-to-back
        req(I_STORE, 0, 32'h10, 32'hDEADBEEF);  cycle();
        req(I_LOAD, 3, 32'h10, 32'h0);          cycle();
        idle();                                 cycle();
        chk("ld_lat1_valid", 64'(s_cdb_valid), 64'd0);
        cycle();
        chk("ld_lat2_valid", 64'(s_cdb_valid), 64'd1);
        chk("ld_lat2_cdb",   64'(s_cdb),       64'h3_DEADBEEF);

        // Credit exhaustion and ordered drain
        cdb_ready = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            req(I_LOADB, r, 32'h10, 32'h0);
            cycle();
        end
        req(I_LOADR, 5, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("ld5_stall", 64'(s_req_ready), 64'd0);
        end
        popped.delete();
        cdb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_req_ready) break;
        end
        chk("ld5_accept", 64'(s_req_ready), 64'd1);
        idle();
        repeat (6) cycle();
        chk("drain_count", 64'(popped.size()), 64'd5);
        for (int i = 0; i < 5 && i < popped.size(); i++)
            chk("drain_order", 64'(popped[i]), 64'(i + 1));

        // INPUT waits for a byte
        in_valid = 1'b0;
        req(I_INPUT, 7, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("in_wait_ready",    64'(s_req_ready), 64'd0);
            chk("in_wait_in_ready", 64'(s_in_ready),  64'd0);
        end
        in_valid = 1'b1;
        in_data  = 8'h41;
        cycle();
        chk("in_pulse", 64'(s_in_ready), 64'd1);
        idle();
        cycle();
        chk("in_pulse_end", 64'(s_in_ready), 64'd0);
        cycle();
        chk("in_cdb", 64'(s_cdb), 64'h7_00000041);
        in_valid = 1'b0;

        // OUTPUT holds until the sink is ready
        out_ready = 1'b0;
        req(I_OUTPUT, 0, 32'h0, 32'h12345678);  cycle();
        req(I_OUTPUT, 0, 32'h0, 32'h000000AB);
        cycle();
        chk("out_hold_valid", 64'(s_out_valid), 64'd1);
        chk("out_hold_data",  64'(s_out_data),  64'h78);
        chk("out_stall",      64'(s_req_ready), 64'd0);
        cycle();
        out_ready = 1'b1;
        cycle();
        chk("out2_accept", 64'(s_req_ready), 64'd1);
        chk("out1_data",   64'(s_out_data),  64'h78);
        idle();
        cycle();
        chk("out2_data", 64'(s_out_data), 64'hAB);
        cycle();
        chk("out_clear", 64'(s_out_valid), 64'd0);

        // Upper address bits alias onto word 0
        req(I_STORE, 0, 32'h0, 32'hCAFEF00D);   cycle();
        req(I_LOAD, 9, 32'h10000, 32'h0);       cycle();
        idle();                                 cycle();
        cycle();
        chk("alias_cdb", 64'(s_cdb), 64'h9_CAFEF00D);

        // Reset flushes in-flight loads
        cdb_ready = 1'b0;
        req(I_LOAD, 10, 32'h1, 32'h0);  cycle();
        req(I_LOAD, 11, 32'h2, 32'h0);  cycle();
        idle();
        nrst = 1'b1;
        cycle();
        nrst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("flush_cdb_valid", 64'(s_cdb_valid), 64'd0);
        end
        for (int r = 12; r < 16; r++) begin
            req(I_LOAD, r, 32'h2, 32'h0);
            cycle();
            chk("post_rst_credit", 64'(s_req_ready), 64'd1);
        end
        idle();
        cdb_ready = 1'b1;
        repeat (6) cycle();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            nrst      = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_opcode  = ops[$urandom_range(0, 9)];
            req_rsv_id  = RSV_ID_W'($urandom);
            req_address = {18'($urandom), addrs[$urandom_range(0, 7)]};
            req_data    = $urandom;
            in_valid    = $urandom_range(0, 1) == 1;
            in_data     = 8'($urandom);
            cdb_ready   = ($urandom_range(0, 3) != 0);
            out_ready   = $urandom_range(0, 1) == 1;
            cycle();
        end
        nrst = 1'b0;
        idle();
        cdb_ready = 1'b1;
        out_ready = 1'b1;
        repeat (8) cycle();
        chk("final_empty", 64'(s_cdb_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
